// File: rtl/bmf_h_decoder_seq.sv
// bmf_h_decoder_seq: sequential, reprogrammable H-side decompressor for
// Boolean-matrix-factorized partitions. Computes y = k * H over the XOR or
// OR semiring and folds one matrix row into the accumulator per cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_we/row/data     write one row of H (honoured in IDLE only)
//   in_valid/ready/k    factor-vector input handshake
//   out_valid/ready/y   reconstructed-output handshake
//   busy                high while accumulating or holding a result
module bmf_h_decoder_seq #(
  parameter int unsigned    K       = 9,
  parameter int unsigned    M       = 10,
  parameter bit             OR_MODE = 1'b0,
  parameter logic [K*M-1:0] H_INIT  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [$clog2(K)-1:0] cfg_row,
  input  logic [M-1:0]         cfg_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K-1:0]         in_k,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M-1:0]         out_y,
  output logic                 busy
);

  localparam int unsigned      RowW    = $clog2(K);
  localparam logic [RowW-1:0]  LastRow = RowW'(K - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e                 state_q, state_d;
  // Row i of H lives at h_q[i]; bit j is the coefficient of k_i for y_j.
  logic [K-1:0][M-1:0]    h_q, h_d;
  logic [M-1:0]           acc_q, acc_d;
  logic [M-1:0]           y_q, y_d;
  logic [RowW-1:0]        idx_q, idx_d;
  logic [K-1:0]           k_q, k_d;

  logic [M-1:0]           term;
  logic [M-1:0]           acc_next;

  assign term     = k_q[idx_q] ? h_q[idx_q] : '0;
  assign acc_next = OR_MODE ? (acc_q | term) : (acc_q ^ term);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    acc_d   = acc_q;
    y_d     = y_q;
    idx_d   = idx_q;
    k_d     = k_q;
    case (state_q)
      StIdle: begin
        // Writes are only accepted here so H is frozen for a whole computation;
        // a write alongside in_valid lands before ACCUM reads row 0.
        if (cfg_we && (cfg_row <= LastRow)) begin
          h_d[cfg_row] = cfg_data;
        end
        if (in_valid) begin
          k_d     = in_k;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        acc_d = acc_next;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastRow) begin
          idx_d   = '0;
          y_d     = acc_next;
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      h_q     <= H_INIT;
      acc_q   <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  // y_q is loaded on entry to HOLD and otherwise retained, so out_y keeps
  // the last result after the handshake.
  assign out_y     = y_q;

endmodule

// File: tb/tb_bmf_h_decoder_seq.sv
// Directed self-checking bench: an XOR-mode and an OR-mode instance share
// all inputs and the same H_INIT partition map.
module tb_bmf_h_decoder_seq;

  localparam int unsigned K = 9;
  localparam int unsigned M = 10;
  // k0->y1, k1->y2, k2->y2,y3, k3->y4, k4->y5, k5->y0,y6, k6->y7, k7->y8,
  // k8->y9,y0,y6 (row 8 first).
  localparam logic [K*M-1:0] HMAP = {10'h241, 10'h100, 10'h080, 10'h041, 10'h020,
                                     10'h010, 10'h00C, 10'h004, 10'h002};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [3:0]   cfg_row;
  logic [M-1:0] cfg_data;
  logic         in_valid;
  logic [K-1:0] in_k;
  logic         out_ready;
  logic         rdy_x, ov_x, busy_x, rdy_o, ov_o, busy_o;
  logic [M-1:0] y_x, y_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bmf_h_decoder_seq #(.K(K), .M(M), .OR_MODE(1'b0), .H_INIT(HMAP)) dut_xor (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(rdy_x), .in_k(in_k), .out_valid(ov_x),
    .out_ready(out_ready), .out_y(y_x), .busy(busy_x)
  );

  bmf_h_decoder_seq #(.K(K), .M(M), .OR_MODE(1'b1), .H_INIT(HMAP)) dut_or (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(rdy_o), .in_k(in_k), .out_valid(ov_o),
    .out_ready(out_ready), .out_y(y_o), .busy(busy_o)
  );

  // Entered at a negedge; presents k for one edge, then waits (bounded) for
  // out_valid. Returns at the negedge where out_valid first reads high.
  task automatic send_vec(input logic [K-1:0] k, output int lat,
                          output logic [M-1:0] yx, output logic [M-1:0] yo);
    in_valid = 1'b1;
    in_k     = k;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!ov_x && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    yx = y_x;
    yo = y_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({rdy_x, ov_x, busy_x, y_x, rdy_o, ov_o, busy_o, y_o} !== {3'b100, 10'h0, 3'b100, 10'h0})
    begin
      failures++;
      $display("FAIL reset_during: got %b/%b/%b/%h %b/%b/%b/%h expected 1/0/0/000",
               rdy_x, ov_x, busy_x, y_x, rdy_o, ov_o, busy_o, y_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy_x, ov_x, busy_x, y_x, rdy_o, ov_o, busy_o, y_o} !== {3'b100, 10'h0, 3'b100, 10'h0})
    begin
      failures++;
      $display("FAIL reset_after: got %b/%b/%b/%h %b/%b/%b/%h expected 1/0/0/000",
               rdy_x, ov_x, busy_x, y_x, rdy_o, ov_o, busy_o, y_o);
    end
  endtask

  task automatic test_multiply();
    logic [K-1:0] kv [3] = '{9'h120, 9'h006, 9'h000};
    logic [M-1:0] ex [3] = '{10'h200, 10'h008, 10'h000};
    logic [M-1:0] eo [3] = '{10'h241, 10'h00C, 10'h000};
    int lat;
    logic [M-1:0] yx, yo;
    for (int i = 0; i < 3; i++) begin
      send_vec(kv[i], lat, yx, yo);
      checks++;
      if (lat != K) begin
        failures++;
        $display("FAIL latency k=%h: got %0d expected %0d", kv[i], lat, K);
      end
      checks++;
      if ({yx, yo} !== {ex[i], eo[i]}) begin
        failures++;
        $display("FAIL product k=%h: got xor=%h or=%h expected xor=%h or=%h",
                 kv[i], yx, yo, ex[i], eo[i]);
      end
      @(negedge clk);
      // out_ready high: one-cycle pulse, straight back to IDLE.
      checks++;
      if ({ov_x, rdy_x, ov_o, rdy_o} !== 4'b0101) begin
        failures++;
        $display("FAIL pulse k=%h: got valid/ready=%b%b expected 01", kv[i], ov_x, rdy_x);
      end
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    int stray;
    logic [M-1:0] yx, yo;
    out_ready = 1'b0;
    send_vec(9'h120, lat, yx, yo);
    checks++;
    if ({yx, yo} !== {10'h200, 10'h241}) begin
      failures++;
      $display("FAIL bp_result: got xor=%h or=%h expected xor=200 or=241", yx, yo);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 1);
      in_k     = 9'h006;
      @(negedge clk);
      checks++;
      if ({ov_x, rdy_x, busy_x, y_x, y_o} !== {3'b101, 10'h200, 10'h241}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: got v/r/b=%b%b%b y=%h/%h expected 101 y=200/241",
                 c, ov_x, rdy_x, busy_x, y_x, y_o);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({ov_x, rdy_x, busy_x, y_x} !== {3'b010, 10'h200}) begin
      failures++;
      $display("FAIL bp_release: got v/r/b=%b%b%b y=%h expected 010 y=200",
               ov_x, rdy_x, busy_x, y_x);
    end
    stray = 0;
    for (int c = 0; c < K + 3; c++) begin
      @(negedge clk);
      if (ov_x || !rdy_x) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL bp_dropped_input: got %0d busy cycles expected 0", stray);
    end
  endtask

  task automatic test_matrix_prog();
    int lat;
    int n;
    logic [M-1:0] yx, yo;
    cfg_we = 1'b1; cfg_row = 4'd0; cfg_data = 10'h3FF;
    @(negedge clk);
    cfg_we = 1'b0;
    send_vec(9'h001, lat, yx, yo);
    checks++;
    if ({yx, yo} !== {10'h3FF, 10'h3FF}) begin
      failures++;
      $display("FAIL prog_row0: got xor=%h or=%h expected 3ff/3ff", yx, yo);
    end
    @(negedge clk);
    // Write during ACCUM must be dropped.
    in_valid = 1'b1; in_k = 9'h001;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_row = 4'd0; cfg_data = 10'h000;
    @(negedge clk);
    cfg_we = 1'b0;
    n = 0;
    while (!ov_x && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({y_x, y_o} !== {10'h3FF, 10'h3FF}) begin
      failures++;
      $display("FAIL prog_accum_write: got xor=%h or=%h expected 3ff/3ff", y_x, y_o);
    end
    @(negedge clk);
    send_vec(9'h001, lat, yx, yo);
    checks++;
    if ({yx, yo} !== {10'h3FF, 10'h3FF}) begin
      failures++;
      $display("FAIL prog_rerun: got xor=%h or=%h expected 3ff/3ff", yx, yo);
    end
    @(negedge clk);
    // Out-of-range row must not touch any row; all-ones k exposes every row.
    cfg_we = 1'b1; cfg_row = 4'd9; cfg_data = 10'h155;
    @(negedge clk);
    cfg_we = 1'b0;
    send_vec(9'h1FF, lat, yx, yo);
    checks++;
    if ({yx, yo} !== {10'h047, 10'h3FF}) begin
      failures++;
      $display("FAIL prog_row9: got xor=%h or=%h expected 047/3ff", yx, yo);
    end
    @(negedge clk);
  endtask

  task automatic test_cfg_with_valid();
    int lat;
    logic [M-1:0] yx, yo;
    cfg_we = 1'b1; cfg_row = 4'd1; cfg_data = 10'h001;
    send_vec(9'h002, lat, yx, yo);
    cfg_we = 1'b0;
    checks++;
    if ({yx, yo} !== {10'h001, 10'h001}) begin
      failures++;
      $display("FAIL cfg_with_valid: got xor=%h or=%h expected 001/001", yx, yo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_accum();
    int lat;
    logic [M-1:0] yx, yo;
    in_valid = 1'b1; in_k = 9'h1FF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy_x, rdy_x} !== 2'b10) begin
      failures++;
      $display("FAIL mid_accum_busy: got busy/ready=%b%b expected 10", busy_x, rdy_x);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy_x, ov_x, busy_x, y_x, rdy_o, ov_o, busy_o, y_o} !== {3'b100, 10'h0, 3'b100, 10'h0})
    begin
      failures++;
      $display("FAIL async_reset: got %b/%b/%b/%h expected 1/0/0/000", rdy_x, ov_x, busy_x, y_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_vec(9'h001, lat, yx, yo);
    checks++;
    if ({yx, yo} !== {10'h002, 10'h002} || lat != K) begin
      failures++;
      $display("FAIL reset_row0: got xor=%h or=%h lat=%0d expected 002/002 lat=9", yx, yo, lat);
    end
    @(negedge clk);
    send_vec(9'h002, lat, yx, yo);
    checks++;
    if ({yx, yo} !== {10'h004, 10'h004}) begin
      failures++;
      $display("FAIL reset_row1: got xor=%h or=%h expected 004/004", yx, yo);
    end
    @(negedge clk);
  endtask

  initial begin
    cfg_we    = 1'b0;
    cfg_row   = '0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    in_k      = '0;
    out_ready = 1'b1;
    test_reset();
    test_multiply();
    test_back_pressure();
    test_matrix_prog();
    test_cfg_with_valid();
    test_reset_mid_accum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
